lfsr_keystream: RTL and testbench

- Generates a pseudo-random keystream word every accepted cycle.
- Drives the b operand of the downstream n-bit XOR stage, forming a simple stream scrambler: s = a XOR key.
- Runs one burst of len_i words per start request, using a valid/ready handshake toward the consumer.
- Based on a Galois LFSR with a seed loaded at burst start.

---
 rtl/lfsr_keystream.sv | 87 ++++++++
 tb/tb_lfsr_keystream.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_keystream.sv
// Burst keystream generator: a Galois LFSR seeded per start request, streamed
// to a consumer over valid/ready, one word per accepted transfer.
module lfsr_keystream #(
    parameter int              nb_g    = 16,
    parameter logic [nb_g-1:0] taps_g  = 16'hB400,
    parameter int              cnt_w_g = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [nb_g-1:0]    seed_i,
    input  logic [cnt_w_g-1:0] len_i,
    output logic [nb_g-1:0]    key_o,
    output logic               key_valid_o,
    input  logic               key_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [nb_g-1:0]    lfsr;
    logic [cnt_w_g-1:0] remaining;

    function automatic logic [nb_g-1:0] galois_step(input logic [nb_g-1:0] cur);
        galois_step = cur[0] ? ((cur >> 1) ^ taps_g) : (cur >> 1);
    endfunction

    // An all-zero state is a fixed point of the LFSR, so a zero seed is replaced by 1.
    function automatic logic [nb_g-1:0] safe_seed(input logic [nb_g-1:0] s);
        safe_seed = (s == '0) ? nb_g'(1) : s;
    endfunction

    assign key_o = lfsr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            lfsr        <= '0;
            remaining   <= '0;
            key_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (len_i != '0) begin
                            lfsr        <= safe_seed(seed_i);
                            remaining   <= len_i;
                            key_valid_o <= 1'b1;
                            state       <= RUN;
                        end else begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                RUN: begin
                    // State only moves on a transfer, so key_o is stable under backpressure.
                    if (key_ready_i) begin
                        lfsr      <= galois_step(lfsr);
                        remaining <= remaining - cnt_w_g'(1);
                        if (remaining == cnt_w_g'(1)) begin
                            key_valid_o <= 1'b0;
                            done_o      <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    key_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_keystream.sv
// Bench for lfsr_keystream: expected key words are queued as bursts are started
// and popped by a monitor on every observed transfer.
module tb_lfsr_keystream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] seed;
    logic [7:0]  len;
    logic [15:0] key;
    logic        key_valid;
    logic        key_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int words  = 0;
    int dones  = 0;
    logic [15:0] q[$];

    lfsr_keystream #(.nb_g(16), .taps_g(16'hB400), .cnt_w_g(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .seed_i(seed), .len_i(len),
        .key_o(key), .key_valid_o(key_valid), .key_ready_i(key_ready),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] galois(input logic [15:0] x);
        galois = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
            logic [15:0] exp;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra_word got %h expected none", key);
            end else begin
                exp = q.pop_front();
                if (key !== exp) begin
                    errors++;
                    $display("FAIL sb_key got %h expected %h", key, exp);
                end
            end
            words++;
        end
        if (rst_n === 1'b1 && done === 1'b1) dones++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [15:0] s, input logic [7:0] l);
        seed  = s;
        len   = l;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push_seq(input logic [15:0] s, input int n);
        logic [15:0] x;
        x = (s == 16'h0) ? 16'h0001 : s;
        for (int i = 0; i < n; i++) begin
            q.push_back(x);
            x = galois(x);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout busy=%b expected 0 within %0d cycles", name, busy, budget);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_words got %0d left expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; seed = '0; len = '0; key_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", key_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        checks++;
        if (key !== 16'h0000) begin errors++; $display("FAIL reset_key got %h expected 0000", key); end
    endtask

    task automatic test_basic();
        int w0 = words;
        int d0 = dones;
        key_ready = 1'b1;
        q.push_back(16'h0001); q.push_back(16'hB400);
        q.push_back(16'h5A00); q.push_back(16'h2D00);
        start_burst(16'h0001, 8'd4);
        checks++;
        if (key_valid !== 1'b1 || key !== 16'h0001) begin
            errors++; $display("FAIL basic_first got v=%b k=%h expected v=1 k=0001", key_valid, key);
        end
        tick(4);
        checks++;
        if (done !== 1'b1 || key_valid !== 1'b0) begin
            errors++; $display("FAIL basic_done got done=%b v=%b expected done=1 v=0", done, key_valid);
        end
        tick(1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle got done=%b busy=%b expected 0 0", done, busy);
        end
        checks++;
        if (words - w0 != 4 || dones - d0 != 1) begin
            errors++; $display("FAIL basic_count got words=%0d dones=%0d expected 4 1", words - w0, dones - d0);
        end
        wait_idle("basic", 10);
    endtask

    task automatic test_backpressure();
        int d0 = dones;
        key_ready = 1'b0;
        q.push_back(16'hACE1); q.push_back(16'hE270); q.push_back(16'h7138);
        start_burst(16'hACE1, 8'd3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (key_valid !== 1'b1 || key !== 16'hACE1) begin
                errors++; $display("FAIL bp_hold got v=%b k=%h expected v=1 k=ace1", key_valid, key);
            end
            tick(1);
        end
        key_ready = 1'b1;
        wait_idle("bp", 20);
        checks++;
        if (dones - d0 != 1) begin errors++; $display("FAIL bp_done_count got %0d expected 1", dones - d0); end
    endtask

    task automatic test_zero();
        int w0, d0;
        key_ready = 1'b1;
        q.push_back(16'h0001); q.push_back(16'hB400);
        start_burst(16'h0000, 8'd2);
        checks++;
        if (key !== 16'h0001) begin errors++; $display("FAIL zero_seed got %h expected 0001", key); end
        wait_idle("zero_seed", 10);
        w0 = words; d0 = dones;
        start_burst(16'h1234, 8'd0);
        checks++;
        if (done !== 1'b1 || key_valid !== 1'b0) begin
            errors++; $display("FAIL zero_len got done=%b v=%b expected done=1 v=0", done, key_valid);
        end
        tick(1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || words != w0 || dones - d0 != 1) begin
            errors++; $display("FAIL zero_len_end got done=%b busy=%b words=%0d dones=%0d expected 0 0 0 1",
                               done, busy, words - w0, dones - d0);
        end
    endtask

    task automatic test_start_busy();
        int w0 = words;
        int d0 = dones;
        key_ready = 1'b1;
        push_seq(16'h1234, 5);
        start_burst(16'h1234, 8'd5);
        tick(1);
        start_burst(16'hFFFF, 8'd9);
        wait_idle("busy_start", 20);
        tick(3);
        checks++;
        if (words - w0 != 5 || dones - d0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_start_count got words=%0d dones=%0d busy=%b expected 5 1 0",
                               words - w0, dones - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = dones;
        key_ready = 1'b1;
        push_seq(16'h0001, 10);
        start_burst(16'h0001, 8'd10);
        tick(2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (key !== 16'h0 || key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid got k=%h v=%b busy=%b done=%b expected 0 0 0 0",
                               key, key_valid, busy, done);
        end
        q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (dones != d0) begin errors++; $display("FAIL rst_mid_done got %0d pulses expected 0", dones - d0); end
        q.push_back(16'h0001); q.push_back(16'hB400);
        start_burst(16'h0001, 8'd2);
        checks++;
        if (key !== 16'h0001) begin errors++; $display("FAIL rst_restart got %h expected 0001", key); end
        wait_idle("rst_restart", 10);
    endtask

    task automatic test_xor();
        logic [15:0] exp_s[3];
        logic [15:0] s;
        exp_s[0] = 16'hFFFE; exp_s[1] = 16'h4BFF; exp_s[2] = 16'hA5FF;
        key_ready = 1'b1;
        q.push_back(16'h0001); q.push_back(16'hB400); q.push_back(16'h5A00);
        start_burst(16'h0001, 8'd3);
        for (int i = 0; i < 3; i++) begin
            s = 16'hFFFF ^ key;
            checks++;
            if (s !== exp_s[i]) begin errors++; $display("FAIL xor_s%0d got %h expected %h", i, s, exp_s[i]); end
            tick(1);
        end
        wait_idle("xor", 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_start_busy();
        test_reset_mid();
        test_xor();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
